// File: rtl/fifo_wr_traffic_gen_if.sv
// Write-port bundle between the traffic generator and the FIFO-side bench logic.
// Latency: none, wires only; the generator registers everything it drives.
// Backpressure: fifo_full_i flows toward the generator, which holds wr_en_o/wr_data_o while it is high.
interface fifo_wr_traffic_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  en_i;
  logic                  fifo_full_i;
  logic                  wr_en_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  done_o;
  logic [15:0]           word_cnt_o;
  logic [15:0]           stall_cnt_o;

  // Generator side: consumes enable/full, produces the write port and counters.
  modport master (
    input  en_i,
    input  fifo_full_i,
    output wr_en_o,
    output wr_data_o,
    output done_o,
    output word_cnt_o,
    output stall_cnt_o
  );

  // FIFO/bench side: drives enable/full, observes the write port and counters.
  modport slave (
    output en_i,
    output fifo_full_i,
    input  wr_en_o,
    input  wr_data_o,
    input  done_o,
    input  word_cnt_o,
    input  stall_cnt_o
  );
endinterface

// File: rtl/fifo_wr_traffic_gen.sv
// Bursty Galois-LFSR write stimulus for an async FIFO, with accepted-word and stall counters.
// Latency: first wr_en_o one cycle after en_i is sampled in IDLE; done_o one cycle after the final accept.
// Backpressure: fifo_full_i while writing freezes wr_en_o/wr_data_o and all progress; only stall_cnt_o moves.
module fifo_wr_traffic_gen #(
  parameter int          DATA_WIDTH = 16,       // 1..16, low bits of the LFSR
  parameter logic [15:0] LFSR_SEED  = 16'hACE1, // zero is replaced by 16'h0001
  parameter int          BURST_LEN  = 8,        // >= 1
  parameter int          IDLE_GAP   = 4,        // 0 gives a continuous stream
  parameter int          NUM_WORDS  = 256       // 1..65535
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  fifo_wr_traffic_gen_if.master wr_if
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // An all-zero Galois LFSR would lock up, so a zero seed is nudged to 1.
  localparam logic [15:0] L_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] L_LFSR_MASK = 16'hB400;
  localparam logic [15:0] L_BURST_LEN = 16'(BURST_LEN);
  localparam logic [15:0] L_IDLE_GAP  = 16'(IDLE_GAP);
  localparam logic [15:0] L_NUM_WORDS = 16'(NUM_WORDS);

  logic [1:0]  r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_burst_cnt;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_word_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_done;

  logic        w_wr_en;
  logic        w_accept;
  logic        w_stall;
  logic        w_last_word;
  logic        w_last_in_burst;
  logic        w_last_gap;
  logic [15:0] w_lfsr_nxt;
  logic [15:0] w_word_cnt_inc;
  logic [15:0] w_burst_cnt_inc;
  logic [15:0] w_gap_cnt_inc;

  // Write enable is a pure decode of the registered state, so it cannot glitch.
  assign w_wr_en  = (r_state == S_BURST);
  assign w_accept = w_wr_en & ~wr_if.fifo_full_i;
  assign w_stall  = w_wr_en &  wr_if.fifo_full_i;

  assign w_lfsr_nxt      = r_lfsr[0] ? ((r_lfsr >> 1) ^ L_LFSR_MASK) : (r_lfsr >> 1);
  assign w_word_cnt_inc  = r_word_cnt + 16'd1;
  assign w_burst_cnt_inc = r_burst_cnt + 16'd1;
  assign w_gap_cnt_inc   = r_gap_cnt + 16'd1;

  assign w_last_word     = (w_word_cnt_inc == L_NUM_WORDS);
  assign w_last_in_burst = (w_burst_cnt_inc == L_BURST_LEN);
  assign w_last_gap      = (w_gap_cnt_inc == L_IDLE_GAP);

  // Sequencer: IDLE -> BURST -> (GAP ->) BURST/IDLE ... -> DONE; a burst only advances on accept.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= 16'd0;
      r_gap_cnt   <= 16'd0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wr_if.en_i) begin
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          // Total-word limit wins over end-of-burst so DONE is never delayed by a gap.
          if (w_accept) begin
            if (w_last_word) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_last_in_burst) begin
              r_burst_cnt <= 16'd0;
              r_state     <= (IDLE_GAP == 0) ? S_BURST : S_GAP;
            end else begin
              r_burst_cnt <= w_burst_cnt_inc;
            end
          end
        end
        S_GAP: begin
          // Enable is only looked at on the final gap cycle, so a gap always runs to length.
          if (w_last_gap) begin
            r_gap_cnt <= 16'd0;
            r_state   <= wr_if.en_i ? S_BURST : S_IDLE;
          end else begin
            r_gap_cnt <= w_gap_cnt_inc;
          end
        end
        default: begin
          // DONE is terminal until reset.
          r_state <= S_DONE;
        end
      endcase
    end
  end

  // Data and word count step together on accept; pausing in IDLE leaves both untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_lfsr     <= L_SEED;
      r_word_cnt <= 16'd0;
    end else if (w_accept) begin
      r_lfsr     <= w_lfsr_nxt;
      r_word_cnt <= w_word_cnt_inc;
    end
  end

  // Stall cycles are counted while writing into a full FIFO, saturating rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign wr_if.wr_en_o     = w_wr_en;
  assign wr_if.wr_data_o   = r_lfsr[DATA_WIDTH-1:0];
  assign wr_if.done_o      = r_done;
  assign wr_if.word_cnt_o  = r_word_cnt;
  assign wr_if.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fifo_wr_traffic_gen.sv
// Bench for fifo_wr_traffic_gen: two instances (gapped bursts, continuous stream).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: fifo_full_i driven from the bench to exercise stalls.
module tb_fifo_wr_traffic_gen;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int n_chk;
  int n_fail;

  fifo_wr_traffic_gen_if #(.DATA_WIDTH(16)) ifa ();
  fifo_wr_traffic_gen_if #(.DATA_WIDTH(16)) ifb ();

  fifo_wr_traffic_gen #(
    .DATA_WIDTH(16), .LFSR_SEED(16'hACE1), .BURST_LEN(8), .IDLE_GAP(4), .NUM_WORDS(16)
  ) dut_a (
    .clk_i  (clk),
    .rst_n_i(rst_a_n),
    .wr_if  (ifa)
  );

  fifo_wr_traffic_gen #(
    .DATA_WIDTH(16), .LFSR_SEED(16'hACE1), .BURST_LEN(8), .IDLE_GAP(0), .NUM_WORDS(20)
  ) dut_b (
    .clk_i  (clk),
    .rst_n_i(rst_b_n),
    .wr_if  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        full;
    logic        exp_wr_en;
    logic        exp_done;
    logic [15:0] exp_word_cnt;
  } vec_t;

  vec_t tbl[24];

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq_a(input int n);
    logic [15:0] v;
    q_a.delete();
    v = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      q_a.push_back(v);
      v = lfsr_step(v);
    end
  endtask

  task automatic push_seq_b(input int n);
    logic [15:0] v;
    q_b.delete();
    v = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      q_b.push_back(v);
      v = lfsr_step(v);
    end
  endtask

  // Called after inputs for the coming edge are set: an accept pops, a stall must hold q[0].
  task automatic sb_a();
    if (rst_a_n && ifa.wr_en_o) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_a_extra: got write %0h, required no write", ifa.wr_data_o);
      end else if (ifa.fifo_full_i) begin
        chk("sb_a_hold", ifa.wr_data_o, q_a[0]);
      end else begin
        chk("sb_a_data", ifa.wr_data_o, q_a.pop_front());
      end
    end
  endtask

  task automatic sb_b();
    if (rst_b_n && ifb.wr_en_o) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_b_extra: got write %0h, required no write", ifb.wr_data_o);
      end else if (ifb.fifo_full_i) begin
        chk("sb_b_hold", ifb.wr_data_o, q_b[0]);
      end else begin
        chk("sb_b_data", ifb.wr_data_o, q_b.pop_front());
      end
    end
  endtask

  task automatic reset_a();
    rst_a_n         = 1'b0;
    ifa.en_i        = 1'b0;
    ifa.fifo_full_i = 1'b0;
    cyc();
    cyc();
    rst_a_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst_a_n         = 1'b0;
    rst_b_n         = 1'b0;
    ifa.en_i        = 1'b0;
    ifa.fifo_full_i = 1'b0;
    ifb.en_i        = 1'b0;
    ifb.fifo_full_i = 1'b0;

    // Timeline for 2x8 words with a 4-cycle gap; index 0 is the first cycle after en_i goes high.
    for (int i = 0; i < 24; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].full      = 1'b0;
      tbl[i].exp_wr_en = ((i < 8) || ((i >= 12) && (i < 20))) ? 1'b1 : 1'b0;
      tbl[i].exp_done  = (i >= 20) ? 1'b1 : 1'b0;
      if (i <= 8)       tbl[i].exp_word_cnt = 16'(i);
      else if (i <= 12) tbl[i].exp_word_cnt = 16'd8;
      else if (i <= 20) tbl[i].exp_word_cnt = 16'(i - 4);
      else              tbl[i].exp_word_cnt = 16'd16;
    end

    // Reset state held with en_i low.
    reset_a();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rst_wr_en", ifa.wr_en_o, 0);
      chk("rst_data", ifa.wr_data_o, 16'hACE1);
      chk("rst_word_cnt", ifa.word_cnt_o, 0);
      chk("rst_stall_cnt", ifa.stall_cnt_o, 0);
      chk("rst_done", ifa.done_o, 0);
    end

    // Two bursts with a gap, then DONE stays put with en_i still high.
    push_seq_a(16);
    ifa.en_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      ifa.en_i        = tbl[i].en;
      ifa.fifo_full_i = tbl[i].full;
      sb_a();
      chk("tbl_wr_en", ifa.wr_en_o, tbl[i].exp_wr_en);
      chk("tbl_done", ifa.done_o, tbl[i].exp_done);
      chk("tbl_word_cnt", ifa.word_cnt_o, tbl[i].exp_word_cnt);
    end
    chk("tbl_sb_empty", q_a.size(), 0);

    // Full for 5 cycles on word 3 and for 2 cycles on the last word of burst 1.
    reset_a();
    push_seq_a(16);
    ifa.en_i = 1'b1;
    begin
      int s1;
      int s2;
      s1 = 0;
      s2 = 0;
      for (int c = 0; c < 100; c++) begin
        cyc();
        ifa.fifo_full_i = 1'b0;
        if ((ifa.word_cnt_o == 16'd2) && (s1 < 5)) begin
          chk("stall3_wr_en", ifa.wr_en_o, 1);
          ifa.fifo_full_i = 1'b1;
          s1++;
        end else if ((ifa.word_cnt_o == 16'd7) && (s2 < 2)) begin
          chk("stall8_wr_en", ifa.wr_en_o, 1);
          ifa.fifo_full_i = 1'b1;
          s2++;
        end
        sb_a();
        if (ifa.done_o) break;
      end
    end
    ifa.fifo_full_i = 1'b0;
    chk("stall_done", ifa.done_o, 1);
    chk("stall_cnt", ifa.stall_cnt_o, 7);
    chk("stall_word_cnt", ifa.word_cnt_o, 16);
    chk("stall_sb_empty", q_a.size(), 0);

    // Drop en_i during the gap: generator parks in IDLE, then resumes the sequence.
    reset_a();
    push_seq_a(16);
    ifa.en_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      sb_a();
    end
    cyc();
    chk("pause_gap_wr_en", ifa.wr_en_o, 0);
    ifa.en_i = 1'b0;
    for (int c = 0; c < 11; c++) begin
      cyc();
      chk("pause_wr_en", ifa.wr_en_o, 0);
    end
    chk("pause_word_cnt", ifa.word_cnt_o, 8);
    chk("pause_data", ifa.wr_data_o, q_a[0]);
    ifa.en_i = 1'b1;
    cyc();
    chk("resume_wr_en", ifa.wr_en_o, 1);
    chk("resume_word_cnt", ifa.word_cnt_o, 8);
    sb_a();
    for (int c = 0; c < 40; c++) begin
      cyc();
      sb_a();
      if (ifa.done_o) break;
    end
    chk("pause_done", ifa.done_o, 1);
    chk("pause_final_cnt", ifa.word_cnt_o, 16);
    chk("pause_sb_empty", q_a.size(), 0);

    // One-cycle reset after the third accept, then a full replay.
    reset_a();
    push_seq_a(16);
    ifa.en_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      sb_a();
    end
    cyc();
    chk("midrst_pre_cnt", ifa.word_cnt_o, 3);
    rst_a_n = 1'b0;
    cyc();
    rst_a_n = 1'b1;
    chk("midrst_wr_en", ifa.wr_en_o, 0);
    chk("midrst_word_cnt", ifa.word_cnt_o, 0);
    chk("midrst_data", ifa.wr_data_o, 16'hACE1);
    push_seq_a(16);
    for (int c = 0; c < 60; c++) begin
      cyc();
      sb_a();
      if (ifa.done_o) break;
    end
    chk("midrst_done", ifa.done_o, 1);
    chk("midrst_final_cnt", ifa.word_cnt_o, 16);
    chk("midrst_sb_empty", q_a.size(), 0);

    // Continuous stream instance: 20 back-to-back writes, then DONE.
    cyc();
    rst_b_n = 1'b1;
    push_seq_b(20);
    ifb.en_i = 1'b1;
    begin
      int run;
      int holes;
      run   = 0;
      holes = 0;
      for (int c = 0; c < 40; c++) begin
        cyc();
        sb_b();
        if (ifb.wr_en_o) run++;
        else if (!ifb.done_o && (run > 0)) holes++;
        if (ifb.done_o) break;
      end
      chk("cont_run", run, 20);
      chk("cont_holes", holes, 0);
    end
    chk("cont_done", ifb.done_o, 1);
    chk("cont_wr_en_off", ifb.wr_en_o, 0);
    chk("cont_word_cnt", ifb.word_cnt_o, 20);
    chk("cont_sb_empty", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
